// File: rtl/cmp42_mult_seq_if.sv
// Operand/result handshake bundle for cmp42_mult_seq.
// The producer/consumer side uses the master modport; the multiplier uses slave.
interface cmp42_mult_seq_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           out_sat;

  modport master (
    output in_valid, in_a, in_b, flush, out_ready,
    input  in_ready, out_valid, out_p, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, flush, out_ready,
    output in_ready, out_valid, out_p, out_sat
  );
endinterface

// File: rtl/cmp42_mult_seq.sv
// Iterative W x W multiplier folding four partial-product rows per cycle through a
// row of approximate 4:2 compressors. Define CMP42_EXACT_EN for an exact-sum build.
module cmp42_mult_seq #(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  cmp42_mult_seq_if.slave   bus
);

  localparam int NG = W / 4;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int PW = 2 * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [W-1:0]         a_reg;
  logic [W-1:0]         b_reg;
  logic [PW-1:0]        acc;
  logic                 sat_acc;
  logic [GW-1:0]        grp;
  logic [PW-1:0]        p_reg;
  logic                 sat_reg;

  logic                 accept;
  logic                 last_grp;
  logic [3:0][PW-1:0]   row;
  logic [PW-1:0]        acc_next;
  logic                 grp_sat;

  // flush outranks the input handshake, so a flushed IDLE cycle accepts nothing.
  assign accept   = (state == IDLE) && bus.in_valid && !bus.flush;
  assign last_grp = (grp == GW'(NG - 1));

  // Partial-product rows of the current group, already aligned to their weight.
  always_comb begin
    row = '0;
    for (int j = 0; j < 4; j++) begin
      if (b_reg[4 * int'(grp) + j]) begin
        row[j] = {{W{1'b0}}, a_reg} << (4 * int'(grp) + j);
      end
    end
  end

`ifdef CMP42_EXACT_EN
  always_comb begin
    acc_next = acc + row[0] + row[1] + row[2] + row[3];
    grp_sat  = 1'b0;
  end
`else
  logic [PW-1:0] cmp_s;
  logic [PW-1:0] cmp_c;

  // Each column saturates at 3: sum + 2*carry = min(popcount, 3), no lateral carry.
  always_comb begin
    cmp_s    = (row[0] & row[1] & row[2]) | (row[0] ^ row[1] ^ row[2] ^ row[3]);
    cmp_c    = (row[0] & row[1]) | (row[2] & row[3]) |
               ((row[0] ^ row[1]) & (row[2] ^ row[3]));
    acc_next = acc + cmp_s + (cmp_c << 1);
    grp_sat  = |(row[0] & row[1] & row[2] & row[3]);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)        state_next = RUN;
      RUN:     if (last_grp)      state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      sat_acc <= 1'b0;
      grp     <= '0;
      p_reg   <= '0;
      sat_reg <= 1'b0;
    end else begin
      if (accept) begin
        a_reg   <= bus.in_a;
        b_reg   <= bus.in_b;
        acc     <= '0;
        sat_acc <= 1'b0;
        grp     <= '0;
      end
      if ((state == RUN) && !bus.flush) begin
        acc     <= acc_next;
        sat_acc <= sat_acc | grp_sat;
        grp     <= last_grp ? '0 : grp + GW'(1);
        // Result registers load only on the RUN->DONE transition and hold otherwise.
        if (last_grp) begin
          p_reg   <= acc_next;
          sat_reg <= sat_acc | grp_sat;
        end
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_p     = p_reg;
  assign bus.out_sat   = sat_reg;

endmodule

// File: doc/cmp42_mult_seq.md
# cmp42_mult_seq

Iterative unsigned W×W multiplier controller that time-shares one row of approximate 4:2 compressor cells across the partial-product rows of a multiply. Each cycle it compresses four partial-product rows into a sum and carry vector, then folds them into a 2W-bit accumulator. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It is the sequencing wrapper for the approximate-multiplier datapath.

## Interface
- `W`, default 8: operand width; must be a multiple of 4 and at least 4.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: reset; asynchronous assert, active-low.
- `in_valid` input, 1 bit: operand pair valid.
- `in_ready` output, 1 bit: block can accept operands.
- `in_a` input, W bits: multiplicand, unsigned.
- `in_b` input, W bits: multiplier, unsigned.
- `flush` input, 1 bit: synchronous abort to IDLE.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: consumer accepts result.
- `out_p` output, 2W bits: product (approximate unless `CMP42_EXACT_EN` is defined).
- `out_sat` output, 1 bit: at least one compressor column saturated during this operation.

## Operation
- **4:2 cell (2W-wide row, column k)**, inputs x1..x4:
  - sum = (x1&x2&x3) | (x1^x2^x3^x4).
  - carry = (x1&x2) | (x3&x4) | ((x1^x2)&(x3^x4)).
  - Net effect: sum + 2·carry = min(popcount, 3). An all-ones column loses 1 at weight 2^k.
  - There is no inter-column carry.
- **Partial-product row r** (0..W-1) = (in_b[r] ? in_a : 0) << r, zero-extended to 2W bits.
- **Group g** (0..W/4-1) consists of rows 4g..4g+3, fed as x1..x4 in row order.
  - Row S = sum vector, row C = carry vector.
  - Accumulator update: acc ← acc + S + (C << 1), computed mod 2^2W. Carry out of bit 2W-1 is discarded; it cannot occur for valid inputs.
- **Saturation flag:** sat_acc |= OR over columns of (x1&x2&x3&x4) for the group.
- **FSM states:** IDLE, RUN, DONE.
  - **IDLE:** in_ready=1. On in_valid&in_ready: latch a and b, acc←0, sat_acc←0, g←0, go to RUN.
  - **RUN:** process group g each cycle. If g==W/4-1, go to DONE; else g←g+1. in_ready=0. in_valid is ignored.
  - **DONE:** out_valid=1; out_p=acc and out_sat=sat_acc, both held stable. On out_ready, go to IDLE. in_ready=0.
- **flush:** forces IDLE from any state on the next edge; any result in flight is discarded.
  - flush has priority over both handshakes in the same cycle.
  - flush in IDLE together with in_valid: the operands are not accepted.
- **Reset (rst_n=0):** state=IDLE, in_ready=1, out_valid=0, out_p=0, out_sat=0, acc=0, g=0.
  - Reset mid-RUN or mid-DONE discards the operation immediately, without waiting for a clock edge.
- out_p and out_sat change only on entry to DONE; they keep their last value while in IDLE and RUN.

## Timing
- Accept edge is T. RUN occupies cycles T+1 .. T+W/4. out_valid=1 from the edge ending cycle T+W/4, i.e. W/4 cycles after accept. For W=8 this is 2 cycles.
- Throughput is one multiply per W/4+2 cycles when out_ready is held at 1 (the accept cycle plus the DONE→IDLE cycle).
- in_ready is a registered state decode: no combinational path from in_valid.
- out_valid is a registered state decode: no combinational path from out_ready.
- Backpressure: DONE is held for as many cycles as out_ready=0, with outputs stable throughout.

## Configuration
- `CMP42_EXACT_EN`
  - **Defined:** each group adds the exact sum of its four rows to acc. out_p = a·b exactly, and out_sat is tied to 0.
  - **Undefined (default):** approximate 4:2 cells as specified above. out_sat reports column saturation.
- Latency, handshakes and FSM are identical in both builds.

## Test plan
- Reset release, then a=0x03, b=0x05, W=8, out_ready=1 → out_valid 2 cycles after accept; out_p=0x000F, out_sat=0.
- a=0xFF, b=0xFF, approximate build → out_p=0xED89 (group 0 loses 248, group 1 loses 3968), out_sat=1. With `CMP42_EXACT_EN` → out_p=0xFE01, out_sat=0.
- a=0x0F, b=0x0F → out_p=0x00D9 (column 3 saturated), out_sat=1. Exact build → out_p=0x00E1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_valid, out_p and out_sat stable; in_ready=0; in_valid pulses are ignored. Release → IDLE on the next edge, then accept the next pair.
- flush asserted in the first RUN cycle of a=0xFF, b=0xFF → IDLE next edge; out_valid never rises; out_p keeps its prior value. The next pair a=0x03, b=0x05 yields 0x000F.
- rst_n pulsed low mid-RUN, then mid-DONE → outputs go to their reset values immediately; the first post-reset multiply is correct.
